// File: rtl/soc_sram_resp.sv
// rtl/soc_sram_resp.sv - CPU inst/data SRAM-port responder with shared RAM and MMIO registers
// Fixed 1-cycle read latency on both ports, read-first on writes, no stall.
module soc_sram_resp #(
  parameter int unsigned ADDR_W    = 14,
  parameter logic [31:0] MMIO_BASE = 32'hBFAF_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        inst_sram_en,
  input  logic [3:0]  inst_sram_we,
  input  logic [31:0] inst_sram_addr,
  input  logic [31:0] inst_sram_wdata,
  output logic [31:0] inst_sram_rdata,
  input  logic        data_sram_en,
  input  logic [3:0]  data_sram_we,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic [31:0] data_sram_rdata,
  output logic [15:0] led,
  output logic        inst_we_err
);

  localparam int unsigned DEPTH       = 1 << ADDR_W;
  localparam logic [13:0] OFF_LED     = 14'd0;
  localparam logic [13:0] OFF_TIMER   = 14'd1;
  localparam logic [13:0] OFF_SCRATCH = 14'd2;

  logic [31:0] ram [DEPTH];

  logic [31:0] inst_rdata_q, inst_rdata_d;
  logic [31:0] data_rdata_q, data_rdata_d;
  logic [15:0] led_q, led_d;
  logic [31:0] timer_q, timer_d;
  logic [31:0] scratch_q, scratch_d;
  logic        inst_we_err_q, inst_we_err_d;

  logic [ADDR_W-1:0] inst_idx, data_idx;
  logic [13:0]       mmio_off;
  logic              data_mmio;
  logic              ram_we;
  logic [31:0]       ram_wdata;
  logic [31:0]       mmio_rdata;
  logic              unused_ok;

  assign inst_idx  = inst_sram_addr[ADDR_W+1:2];
  assign data_idx  = data_sram_addr[ADDR_W+1:2];
  assign mmio_off  = data_sram_addr[15:2];
  assign data_mmio = (data_sram_addr[31:16] == MMIO_BASE[31:16]);
  assign unused_ok = ^{inst_sram_wdata, inst_sram_addr, data_sram_addr};

  function automatic logic [31:0] byte_merge(input logic [31:0] old_word,
                                             input logic [31:0] new_word,
                                             input logic [3:0]  be);
    logic [31:0] res;
    res = old_word;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) res[8*i +: 8] = new_word[8*i +: 8];
    end
    return res;
  endfunction

  always_comb begin
    inst_rdata_d  = inst_rdata_q;
    data_rdata_d  = data_rdata_q;
    led_d         = led_q;
    timer_d       = timer_q + 32'd1;
    scratch_d     = scratch_q;
    inst_we_err_d = inst_we_err_q;
    ram_we        = 1'b0;
    ram_wdata     = byte_merge(ram[data_idx], data_sram_wdata, data_sram_we);

    case (mmio_off)
      OFF_LED:     mmio_rdata = {16'h0000, led_q};
      OFF_TIMER:   mmio_rdata = timer_q;
      OFF_SCRATCH: mmio_rdata = scratch_q;
      default:     mmio_rdata = 32'h0000_0000;
    endcase

    // The instruction port never writes RAM; a write attempt only raises the sticky flag.
    if (inst_sram_en) begin
      inst_rdata_d = ram[inst_idx];
      if (|inst_sram_we) inst_we_err_d = 1'b1;
    end

    if (data_sram_en) begin
      data_rdata_d = data_mmio ? mmio_rdata : ram[data_idx];
      if (|data_sram_we) begin
        if (!data_mmio) begin
          ram_we = !reset;
        end else begin
          case (mmio_off)
            OFF_LED: begin
              if (data_sram_we[0]) led_d[7:0]  = data_sram_wdata[7:0];
              if (data_sram_we[1]) led_d[15:8] = data_sram_wdata[15:8];
            end
            OFF_TIMER:   timer_d   = byte_merge(timer_q + 32'd1, data_sram_wdata, data_sram_we);
            OFF_SCRATCH: scratch_d = byte_merge(scratch_q, data_sram_wdata, data_sram_we);
            default: ;
          endcase
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      inst_rdata_q  <= 32'h0;
      data_rdata_q  <= 32'h0;
      led_q         <= 16'h0;
      timer_q       <= 32'h0;
      scratch_q     <= 32'h0;
      inst_we_err_q <= 1'b0;
    end else begin
      inst_rdata_q  <= inst_rdata_d;
      data_rdata_q  <= data_rdata_d;
      led_q         <= led_d;
      timer_q       <= timer_d;
      scratch_q     <= scratch_d;
      inst_we_err_q <= inst_we_err_d;
    end
  end

  // RAM contents survive reset; writes are blocked while reset is high via ram_we.
  always_ff @(posedge clk) begin
    if (ram_we) ram[data_idx] <= ram_wdata;
  end

  assign inst_sram_rdata = inst_rdata_q;
  assign data_sram_rdata = data_rdata_q;
  assign led             = led_q;
  assign inst_we_err     = inst_we_err_q;

endmodule

// File: tb/tb_soc_sram_resp.sv
// tb/tb_soc_sram_resp.sv - self-checking bench for soc_sram_resp against a transaction-level model
module tb_soc_sram_resp;

  localparam int          ADDR_W = 14;
  localparam logic [31:0] MMIO   = 32'hBFAF_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        inst_sram_en;
  logic [3:0]  inst_sram_we;
  logic [31:0] inst_sram_addr, inst_sram_wdata, inst_sram_rdata;
  logic        data_sram_en;
  logic [3:0]  data_sram_we;
  logic [31:0] data_sram_addr, data_sram_wdata, data_sram_rdata;
  logic [15:0] led;
  logic        inst_we_err;

  int checks   = 0;
  int failures = 0;

  logic [31:0] mem [int];
  logic [15:0] m_led;
  logic [31:0] m_timer, m_scratch, exp_inst, exp_data;
  logic        m_err;

  soc_sram_resp #(.ADDR_W(ADDR_W), .MMIO_BASE(MMIO)) dut (
    .clk(clk), .reset(reset),
    .inst_sram_en(inst_sram_en), .inst_sram_we(inst_sram_we),
    .inst_sram_addr(inst_sram_addr), .inst_sram_wdata(inst_sram_wdata),
    .inst_sram_rdata(inst_sram_rdata),
    .data_sram_en(data_sram_en), .data_sram_we(data_sram_we),
    .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata),
    .data_sram_rdata(data_sram_rdata),
    .led(led), .inst_we_err(inst_we_err)
  );

  always #5 clk = ~clk;

  function automatic int widx(input logic [31:0] a);
    return int'((a >> 2) & ((32'd1 << ADDR_W) - 32'd1));
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] be);
    logic [31:0] r;
    r = o;
    for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = n[8*i +: 8];
    return r;
  endfunction

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    int k;
    k = widx(a);
    if (mem.exists(k)) return mem[k];
    return 32'hxxxx_xxxx;
  endfunction

  task automatic model_reset();
    m_led = 16'h0; m_timer = 32'h0; m_scratch = 32'h0;
    exp_inst = 32'h0; exp_data = 32'h0; m_err = 1'b0;
  endtask

  // Drives one bus cycle, advances the model by one clock, returns #1 after the edge.
  task automatic cycle(input logic ie, input logic [3:0] iwe, input logic [31:0] ia,
                       input logic de, input logic [3:0] dwe, input logic [31:0] da,
                       input logic [31:0] dwd);
    logic [31:0] nt, tmp;
    int k;
    inst_sram_en = ie; inst_sram_we = iwe; inst_sram_addr = ia; inst_sram_wdata = $urandom;
    data_sram_en = de; data_sram_we = dwe; data_sram_addr = da; data_sram_wdata = dwd;
    nt = m_timer + 32'd1;
    if (ie) begin
      exp_inst = mem_rd(ia);
      if (iwe != 4'h0) m_err = 1'b1;
    end
    if (de) begin
      if (da[31:16] == MMIO[31:16]) begin
        case (int'(da[15:2]))
          0: begin
            exp_data = {16'h0, m_led};
            tmp = merge({16'h0, m_led}, dwd, dwe & 4'b0011);
            m_led = tmp[15:0];
          end
          1: begin exp_data = m_timer; nt = merge(nt, dwd, dwe); end
          2: begin exp_data = m_scratch; m_scratch = merge(m_scratch, dwd, dwe); end
          default: exp_data = 32'h0;
        endcase
      end else begin
        exp_data = mem_rd(da);
        if (dwe != 4'h0) begin
          k = widx(da);
          mem[k] = merge(mem.exists(k) ? mem[k] : 32'hxxxx_xxxx, dwd, dwe);
        end
      end
    end
    m_timer = nt;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cycle(1'b0, 4'h0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    #1 reset = 1'b1;
    model_reset();
    #1;
    checks++; if (inst_sram_rdata !== 32'h0) begin failures++; $display("FAIL reset_inst_rdata got=%h want=0", inst_sram_rdata); end
    checks++; if (data_sram_rdata !== 32'h0) begin failures++; $display("FAIL reset_data_rdata got=%h want=0", data_sram_rdata); end
    checks++; if (led !== 16'h0) begin failures++; $display("FAIL reset_led got=%h want=0", led); end
    checks++; if (inst_we_err !== 1'b0) begin failures++; $display("FAIL reset_inst_we_err got=%b want=0", inst_we_err); end
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;
    idle();
    checks++; if (data_sram_rdata !== 32'h0) begin failures++; $display("FAIL post_reset_data_rdata got=%h want=0", data_sram_rdata); end
    checks++; if (inst_sram_rdata !== 32'h0) begin failures++; $display("FAIL post_reset_inst_rdata got=%h want=0", inst_sram_rdata); end
  endtask

  task automatic test_ram_basic();
    cycle(1'b0, 4'h0, 32'h0, 1'b1, 4'hF, 32'h1C00_0010, 32'h1234_5678);
    cycle(1'b0, 4'h0, 32'h0, 1'b1, 4'h0, 32'h1C00_0010, 32'h0);
    checks++; if (data_sram_rdata !== 32'h1234_5678) begin failures++; $display("FAIL ram_full_write got=%h want=12345678", data_sram_rdata); end
    // Partial write with a simultaneous instruction read of the same word.
    cycle(1'b1, 4'h0, 32'h1C00_0010, 1'b1, 4'b0010, 32'h1C00_0010, 32'hFFFF_ABFF);
    checks++; if (inst_sram_rdata !== 32'h1234_5678) begin failures++; $display("FAIL inst_read_during_write got=%h want=12345678", inst_sram_rdata); end
    checks++; if (data_sram_rdata !== 32'h1234_5678) begin failures++; $display("FAIL data_read_first got=%h want=12345678", data_sram_rdata); end
    cycle(1'b0, 4'h0, 32'h0, 1'b1, 4'h0, 32'h1C00_0010, 32'h0);
    checks++; if (data_sram_rdata !== 32'h1234_AB78) begin failures++; $display("FAIL ram_byte_write got=%h want=1234ab78", data_sram_rdata); end
    idle();
    checks++; if (data_sram_rdata !== 32'h1234_AB78) begin failures++; $display("FAIL data_rdata_hold got=%h want=1234ab78", data_sram_rdata); end
  endtask

  task automatic test_alias();
    cycle(1'b1, 4'h0, 32'h1C00_0010 + (32'd4 << ADDR_W), 1'b1, 4'h0, 32'h1C00_0010 + (32'd4 << ADDR_W), 32'h0);
    checks++; if (data_sram_rdata !== 32'h1234_AB78) begin failures++; $display("FAIL alias_data got=%h want=1234ab78", data_sram_rdata); end
    checks++; if (inst_sram_rdata !== 32'h1234_AB78) begin failures++; $display("FAIL alias_inst got=%h want=1234ab78", inst_sram_rdata); end
  endtask

  task automatic test_mmio();
    cycle(1'b0, 4'h0, 32'h0, 1'b1, 4'hF, 32'hBFAF_0004, 32'hFFFF_FFFE);
    idle();
    idle();
    cycle(1'b0, 4'h0, 32'h0, 1'b1, 4'h0, 32'hBFAF_0004, 32'h0);
    checks++; if (data_sram_rdata !== 32'h0) begin failures++; $display("FAIL timer_wrap got=%h want=0", data_sram_rdata); end
    checks++; if (data_sram_rdata !== exp_data) begin failures++; $display("FAIL timer_model got=%h want=%h", data_sram_rdata, exp_data); end
    cycle(1'b0, 4'h0, 32'h0, 1'b1, 4'hF, 32'hBFAF_0000, 32'hDEAD_BEEF);
    checks++; if (led !== 16'hBEEF) begin failures++; $display("FAIL led_write got=%h want=beef", led); end
    cycle(1'b0, 4'h0, 32'h0, 1'b1, 4'h0, 32'hBFAF_0000, 32'h0);
    checks++; if (data_sram_rdata !== 32'h0000_BEEF) begin failures++; $display("FAIL led_read got=%h want=0000beef", data_sram_rdata); end
    cycle(1'b0, 4'h0, 32'h0, 1'b1, 4'hF, 32'hBFAF_0008, 32'hA5A5_5A5A);
    cycle(1'b0, 4'h0, 32'h0, 1'b1, 4'b1001, 32'hBFAF_0008, 32'h1122_3344);
    checks++; if (data_sram_rdata !== 32'hA5A5_5A5A) begin failures++; $display("FAIL scratch_read_first got=%h want=a5a55a5a", data_sram_rdata); end
    cycle(1'b0, 4'h0, 32'h0, 1'b1, 4'h0, 32'hBFAF_0008, 32'h0);
    checks++; if (data_sram_rdata !== 32'h11A5_5A44) begin failures++; $display("FAIL scratch_byte_write got=%h want=11a55a44", data_sram_rdata); end
    cycle(1'b0, 4'h0, 32'h0, 1'b1, 4'hF, 32'hBFAF_000C, 32'hFFFF_FFFF);
    cycle(1'b0, 4'h0, 32'h0, 1'b1, 4'h0, 32'hBFAF_000C, 32'h0);
    checks++; if (data_sram_rdata !== 32'h0) begin failures++; $display("FAIL mmio_other got=%h want=0", data_sram_rdata); end
  endtask

  task automatic test_inst_we_err();
    cycle(1'b1, 4'h1, 32'h1C00_0010, 1'b0, 4'h0, 32'h0, 32'h0);
    checks++; if (inst_we_err !== 1'b1) begin failures++; $display("FAIL inst_we_err_set got=%b want=1", inst_we_err); end
    checks++; if (inst_sram_rdata !== 32'h1234_AB78) begin failures++; $display("FAIL inst_we_read got=%h want=1234ab78", inst_sram_rdata); end
    idle();
    cycle(1'b0, 4'h0, 32'h0, 1'b1, 4'h0, 32'h1C00_0010, 32'h0);
    checks++; if (data_sram_rdata !== 32'h1234_AB78) begin failures++; $display("FAIL inst_we_ram_unchanged got=%h want=1234ab78", data_sram_rdata); end
    checks++; if (inst_we_err !== 1'b1) begin failures++; $display("FAIL inst_we_err_sticky got=%b want=1", inst_we_err); end
  endtask

  function automatic logic [31:0] pool_addr(input int k);
    logic [31:0] a;
    a = $urandom;
    a[15:2] = 14'(k * 37 + 5);
    if (a[31:16] == MMIO[31:16]) a[31] = ~a[31];
    return a;
  endfunction

  task automatic test_back_to_back();
    logic [31:0] ia, da, wd;
    logic [3:0]  iwe, dwe;
    logic        ie, de;
    int          r;
    for (int k = 0; k < 8; k++) cycle(1'b0, 4'h0, 32'h0, 1'b1, 4'hF, pool_addr(k), $urandom);
    for (int n = 0; n < 250; n++) begin
      ie  = 1'($urandom_range(0, 1));
      iwe = ($urandom_range(0, 24) == 0) ? 4'($urandom_range(1, 15)) : 4'h0;
      ia  = pool_addr($urandom_range(0, 7));
      wd  = $urandom;
      dwe = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(0, 15)) : 4'h0;
      r   = $urandom_range(0, 9);
      de  = (r != 9);
      if (r <= 5) da = pool_addr($urandom_range(0, 7));
      else da = MMIO | (32'($urandom_range(0, 4)) << 2);
      cycle(ie, iwe, ia, de, dwe, da, wd);
      checks++; if (inst_sram_rdata !== exp_inst) begin failures++; $display("FAIL rand_inst n=%0d got=%h want=%h", n, inst_sram_rdata, exp_inst); end
      checks++; if (data_sram_rdata !== exp_data) begin failures++; $display("FAIL rand_data n=%0d got=%h want=%h", n, data_sram_rdata, exp_data); end
      checks++; if (led !== m_led) begin failures++; $display("FAIL rand_led n=%0d got=%h want=%h", n, led, m_led); end
      checks++; if (inst_we_err !== m_err) begin failures++; $display("FAIL rand_err n=%0d got=%b want=%b", n, inst_we_err, m_err); end
    end
  endtask

  task automatic test_reset_mid();
    cycle(1'b0, 4'h0, 32'h0, 1'b1, 4'hF, 32'hBFAF_0000, 32'h0000_1234);
    cycle(1'b0, 4'h0, 32'h0, 1'b1, 4'hF, 32'hBFAF_0008, 32'h0BAD_F00D);
    // Read request on the bus, reset arrives before the edge that would answer it.
    data_sram_en = 1'b1; data_sram_we = 4'h0; data_sram_addr = 32'h1C00_0010;
    #2 reset = 1'b1;
    model_reset();
    #1;
    checks++; if (data_sram_rdata !== 32'h0) begin failures++; $display("FAIL mid_reset_data got=%h want=0", data_sram_rdata); end
    checks++; if (led !== 16'h0) begin failures++; $display("FAIL mid_reset_led got=%h want=0", led); end
    checks++; if (inst_we_err !== 1'b0) begin failures++; $display("FAIL mid_reset_err got=%b want=0", inst_we_err); end
    @(posedge clk); #1;
    checks++; if (data_sram_rdata !== 32'h0) begin failures++; $display("FAIL reset_held_data got=%h want=0", data_sram_rdata); end
    reset = 1'b0;
    cycle(1'b0, 4'h0, 32'h0, 1'b1, 4'h0, 32'hBFAF_0004, 32'h0);
    checks++; if (data_sram_rdata !== 32'h0) begin failures++; $display("FAIL timer_after_reset got=%h want=0", data_sram_rdata); end
    cycle(1'b0, 4'h0, 32'h0, 1'b1, 4'h0, 32'hBFAF_0008, 32'h0);
    checks++; if (data_sram_rdata !== 32'h0) begin failures++; $display("FAIL scratch_after_reset got=%h want=0", data_sram_rdata); end
    cycle(1'b1, 4'h0, 32'h1C00_0010, 1'b1, 4'h0, 32'h1C00_0010, 32'h0);
    checks++; if (data_sram_rdata !== 32'h1234_AB78) begin failures++; $display("FAIL ram_kept_data got=%h want=1234ab78", data_sram_rdata); end
    checks++; if (inst_sram_rdata !== exp_inst) begin failures++; $display("FAIL ram_kept_inst got=%h want=%h", inst_sram_rdata, exp_inst); end
  endtask

  initial begin
    inst_sram_en = 1'b0; inst_sram_we = 4'h0; inst_sram_addr = 32'h0; inst_sram_wdata = 32'h0;
    data_sram_en = 1'b0; data_sram_we = 4'h0; data_sram_addr = 32'h0; data_sram_wdata = 32'h0;
    test_reset();
    test_ram_basic();
    test_alias();
    test_mmio();
    test_inst_we_err();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/soc_sram_resp.md
SOC_SRAM_RESP -- requirements
Module: soc_sram_resp

Interface
REQ-001 Parameter ADDR_W, default 14, meaning word-address bits of backing RAM (2^ADDR_W words of 32 bits).
REQ-002 Parameter MMIO_BASE, default 32'hBFAF_0000, meaning base of 64 KB MMIO window, decoded on addr[31:16].
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 inst_sram_en  input  1  instruction-port access request.
REQ-006 inst_sram_we  input  4  instruction-port byte write enables; always 0 by protocol.
REQ-007 inst_sram_addr  input  32  instruction byte address.
REQ-008 inst_sram_wdata  input  32  unused write data.
REQ-009 inst_sram_rdata  output  32  instruction read data.
REQ-010 data_sram_en  input  1  data-port access request.
REQ-011 data_sram_we  input  4  data-port byte write enables; bit i writes wdata[8i+7:8i].
REQ-012 data_sram_addr  input  32  data byte address.
REQ-013 data_sram_wdata  input  32  data write data.
REQ-014 data_sram_rdata  output  32  data read data.
REQ-015 led  output  16  LED register value.
REQ-016 inst_we_err  output  1  sticky flag: write attempted on instruction port.

Function
REQ-017 Block SHALL be the responder for the CPU's inst/data SRAM ports: no ready/stall, fixed 1-cycle read latency.
REQ-018 RAM SHALL be a single shared array, word index = addr[ADDR_W+1:2]; addr[1:0] ignored; higher address bits ignored (aliasing/wrap-around) except MMIO decode.
REQ-019 Inst port: cycle N with en=1 -> inst_sram_rdata at cycle N+1 = RAM word at N; en=0 -> rdata holds last value.
REQ-020 Inst port with en=1 and we!=0 SHALL not modify RAM, SHALL still return read data, and SHALL set inst_we_err to 1 until reset.
REQ-021 Data access is MMIO when addr[31:16]==MMIO_BASE[31:16], else RAM.
REQ-022 Data RAM write (en=1, we!=0): only enabled bytes updated at the clock edge; same-cycle data_sram_rdata next cycle SHALL be the old word (read-first).
REQ-023 Data read (en=1, we=0): data_sram_rdata at N+1 = target word at N; en=0 -> rdata holds.
REQ-024 Simultaneous inst read and data write to same word: inst rdata SHALL return the old word.
REQ-025 MMIO offset 0x0 LED: RW, bits[15:0] byte-writable, reads zero-extended; drives led.
REQ-026 MMIO offset 0x4 TIMER: 32-bit, increments by 1 every cycle, wraps 32'hFFFF_FFFF -> 0; byte-masked write loads written bytes (unwritten bytes take incremented value) and write wins over increment that cycle; read returns value before the edge.
REQ-027 MMIO offset 0x8 SCRATCH: 32-bit RW, byte-masked.
REQ-028 Other MMIO offsets: reads return 32'h0, writes ignored.
REQ-029 MMIO reads obey same 1-cycle latency and read-first rule as RAM.

Reset
REQ-030 reset asserted SHALL immediately force inst_sram_rdata, data_sram_rdata, led, TIMER, SCRATCH, inst_we_err to 0; RAM contents not reset.
REQ-031 Accesses in any cycle with reset high SHALL have no effect; rdata remains 0 in the first cycle after release unless an access occurs.
REQ-032 Reset asserted mid-operation (between request and response) SHALL discard the pending response.

Verification
REQ-033 Data write addr 0x1C00_0010 we=4'b1111 wdata=32'h1234_5678, then read same addr -> data_sram_rdata=32'h1234_5678 one cycle after read.
REQ-034 Then write we=4'b0010 wdata=32'hFFFF_ABFF -> read returns 32'h1234_AB78; same-cycle inst read of 0x1C00_0010 during the write returns 32'h1234_5678.
REQ-035 Read data addr 0x1C00_0010 + (4<<ADDR_W) -> returns same word as 0x1C00_0010 (aliasing).
REQ-036 Write TIMER 0xBFAF_0004 wdata=32'hFFFF_FFFE we=4'hF, read two cycles later -> 32'h0000_0000 (wrap); LED write 32'hDEAD_BEEF -> led=16'hBEEF, read returns 32'h0000_BEEF.
REQ-037 Inst port en=1 we=4'h1 -> inst_we_err=1 next cycle, RAM unchanged; remains 1 until reset.
REQ-038 Assert reset mid-cycle after a data read request -> data_sram_rdata=0, led=0, TIMER reads 0 in first read after release, RAM word still 32'h1234_AB78.
